// File: rtl/j_piso_transmitter.sv
// Parallel-in serial-out transmitter.
// A word is taken on a valid/ready handshake and shifted out one bit per clock.
// Frame strobes mark the first and last bits. Back-to-back words stream with no
// idle gap, because a new word can be accepted on the last-bit cycle.
module j_piso_transmitter #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(WIDTH - 2);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    count;

  logic             is_last;
  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] shifted;

  // The bit currently on sout always sits at the outgoing end of shreg.
  // Shifting moves the following bit into that position.
  assign is_last   = (count == LAST);
  assign din_ready = (state == IDLE) || ((state == SHIFT) && is_last);
  assign accept    = din_valid && din_ready;
  assign busy      = (state == SHIFT);
  assign first_bit = MSB_FIRST ? din[WIDTH-1] : din[0];
  assign next_bit  = MSB_FIRST ? shreg[WIDTH-2] : shreg[1];
  assign shifted   = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};

  // Single FSM: the serial outputs are registered and describe the cycle after each edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      count       <= '0;
      sout        <= IDLE_LEVEL;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
    end else if (accept) begin
      state       <= SHIFT;
      shreg       <= din;
      count       <= '0;
      sout        <= first_bit;
      sout_valid  <= 1'b1;
      frame_start <= 1'b1;
      frame_end   <= 1'b0;
    end else if (state == SHIFT) begin
      if (!is_last) begin
        count       <= count + CW'(1);
        shreg       <= shifted;
        sout        <= next_bit;
        sout_valid  <= 1'b1;
        frame_start <= 1'b0;
        frame_end   <= (count == PRE_LAST);
      end else begin
        state       <= IDLE;
        sout        <= IDLE_LEVEL;
        sout_valid  <= 1'b0;
        frame_start <= 1'b0;
        frame_end   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_j_piso_transmitter.sv
// Self-checking bench for j_piso_transmitter.
// Two instances receive identical inputs: one sends MSB first, the other LSB first.
// A queue-based model predicts the serial stream for each cycle from the words accepted.
module tb_j_piso_transmitter;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] din;
  logic         din_valid;

  logic ready_m, sout_m, valid_m, start_m, end_m, busy_m;
  logic ready_l, sout_l, valid_l, start_l, end_l, busy_l;

  int total;
  int bad;

  typedef struct packed {
    logic valid;
    logic bm;
    logic bl;
    logic first;
    logic last;
  } ent_t;

  ent_t pend[$];
  ent_t cur;
  logic mready;

  j_piso_transmitter #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(ready_m),
    .sout(sout_m), .sout_valid(valid_m), .frame_start(start_m), .frame_end(end_m),
    .busy(busy_m)
  );

  j_piso_transmitter #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(ready_l),
    .sout(sout_l), .sout_valid(valid_l), .frame_start(start_l), .frame_end(end_l),
    .busy(busy_l)
  );

  // Free-running clock with the rising edge at 5 ns, 15 ns and so on.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b want %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutputs();
    check("sout_m",  sout_m,  cur.valid ? cur.bm : 1'b0);
    check("sout_l",  sout_l,  cur.valid ? cur.bl : 1'b0);
    check("valid_m", valid_m, cur.valid);
    check("valid_l", valid_l, cur.valid);
    check("start_m", start_m, cur.valid && cur.first);
    check("start_l", start_l, cur.valid && cur.first);
    check("end_m",   end_m,   cur.valid && cur.last);
    check("end_l",   end_l,   cur.valid && cur.last);
    check("busy_m",  busy_m,  cur.valid);
    check("busy_l",  busy_l,  cur.valid);
  endtask

  // Call at a falling edge: checks ready, drives inputs, advances one clock,
  // and checks the outputs at the next falling edge.
  task automatic step(input logic v, input logic [W-1:0] d);
    mready = !cur.valid || cur.last;
    check("ready_m", ready_m, mready);
    check("ready_l", ready_l, mready);
    din       = d;
    din_valid = v;
    @(posedge clk);
    if (v && mready) begin
      for (int i = 0; i < W; i++) begin
        pend.push_back('{valid: 1'b1, bm: d[W-1-i], bl: d[i],
                         first: (i == 0), last: (i == W-1)});
      end
    end
    if (pend.size() > 0) cur = pend.pop_front();
    else cur = '0;
    @(negedge clk);
    checkOutputs();
  endtask

  // Assert reset between edges; the outputs must clear without a clock edge.
  task automatic doReset();
    #2 rst = 1'b1;
    din_valid = 1'b0;
    #1;
    pend.delete();
    cur = '0;
    checkOutputs();
    check("rst_ready_m", ready_m, 1'b1);
    check("rst_ready_l", ready_l, 1'b1);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    cur       = '0;
    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;
    @(negedge clk);
    checkOutputs();
    rst = 1'b0;

    // A single word A5, then idle.
    step(1'b1, 8'hA5);
    for (int i = 0; i < 9; i++) step(1'b0, 8'h00);

    // A5 followed by 3C with valid held; the frames must be contiguous.
    step(1'b1, 8'hA5);
    for (int i = 0; i < 8; i++) step(1'b1, 8'h3C);
    for (int i = 0; i < 9; i++) step(1'b0, 8'h00);

    // The word 01 exercises LSB-first ordering on the second instance.
    step(1'b1, 8'h01);
    for (int i = 0; i < 9; i++) step(1'b0, 8'h00);

    // Reset partway through an FF frame, then confirm the block stays idle.
    step(1'b1, 8'hFF);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00);
    doReset();
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00);

    // A valid pulse while busy is ignored.
    step(1'b1, 8'hA5);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    step(1'b1, 8'h00);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) doReset();
      else step($urandom_range(0, 3) != 0, W'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
